// File: rtl/clip_to_screen.sv
// clip_to_screen: perspective divide and viewport transform of clip-space vertices
// Ports:
//   i_clk, i_reset_n           clock (rising edge), asynchronous active-low reset
//   i_vertex, i_valid, o_ready clip-space vertex {x,y,z,w} input handshake
//   o_screen_x, o_screen_y     screen position, fixed point, y pointing down
//   o_depth                    NDC z, fixed point
//   o_culled                   vertex had w <= 0; screen outputs are zero
//   o_valid, i_ready           output handshake; outputs hold while o_valid is high
module clip_to_screen #(
    parameter int WIDTH      = 32,
    parameter int FRAC       = 16,
    parameter int VIEWPORT_W = 640,
    parameter int VIEWPORT_H = 480
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [4*WIDTH-1:0] i_vertex,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [WIDTH-1:0]   o_screen_x,
    output logic [WIDTH-1:0]   o_screen_y,
    output logic [WIDTH-1:0]   o_depth,
    output logic               o_culled,
    output logic               o_valid,
    input  logic               i_ready
);
    localparam int DIV_STEPS = 2 * FRAC + 1;
    localparam int CW = $clog2(DIV_STEPS);
    localparam int QW = DIV_STEPS > WIDTH ? DIV_STEPS : WIDTH;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;
    localparam logic [WIDTH-1:0] HALF_W = WIDTH'(VIEWPORT_W) << (FRAC - 1);
    localparam logic [WIDTH-1:0] HALF_H = WIDTH'(VIEWPORT_H) << (FRAC - 1);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, DIVIDE, SCALE, DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     x_q, x_d, y_q, y_d, z_q, z_d, w_q, w_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [DIV_STEPS-1:0] dvd_q, dvd_d;
    logic [QW-1:0]        quo_q, quo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     sx_q, sx_d, sy_q, sy_d, dp_q, dp_d;
    logic                 culled_q, culled_d, valid_q, valid_d, ready_q, ready_d;
    logic                 accept, cull, q_bit;
    logic [WIDTH:0]       r_sh;
    logic [WIDTH-1:0]     w_in, recip, ndc_x, ndc_y, ndc_z;

    // Signed fixed-point multiply; the double-width product is shifted and wraps to WIDTH.
    function automatic logic [WIDTH-1:0] fmul(input logic signed [WIDTH-1:0] a,
                                              input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] ae, be;
        ae = (2*WIDTH)'(a);
        be = (2*WIDTH)'(b);
        return WIDTH'((ae * be) >>> FRAC);
    endfunction

    always_comb begin
        w_in = i_vertex[WIDTH-1:0];
        accept = i_valid & ready_q;
        cull = w_in[WIDTH-1] | ~|w_in;
        // Restoring step: shift the next dividend bit (MSB first) into the remainder.
        r_sh = {rem_q, dvd_q[DIV_STEPS-1]};
        q_bit = r_sh >= {1'b0, w_q};
        // Small w gives a reciprocal beyond the positive range; clamp it.
        recip = (quo_q > QW'(MAX_POS)) ? MAX_POS : quo_q[WIDTH-1:0];
        ndc_x = fmul(x_q, recip);
        ndc_y = fmul(y_q, recip);
        ndc_z = fmul(z_q, recip);
        state_d = state_q;
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        w_d = w_q;
        rem_d = rem_q;
        dvd_d = dvd_q;
        quo_d = quo_q;
        cnt_d = cnt_q;
        sx_d = sx_q;
        sy_d = sy_q;
        dp_d = dp_q;
        culled_d = culled_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: if (accept) begin
                x_d = i_vertex[4*WIDTH-1:3*WIDTH];
                y_d = i_vertex[3*WIDTH-1:2*WIDTH];
                z_d = i_vertex[2*WIDTH-1:WIDTH];
                w_d = w_in;
                culled_d = cull;
                rem_d = '0;
                dvd_d = DIV_STEPS'(1) << (2 * FRAC);
                quo_d = '0;
                cnt_d = '0;
                if (cull) begin
                    sx_d = '0;
                    sy_d = '0;
                    dp_d = '0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                rem_d = q_bit ? WIDTH'(r_sh - {1'b0, w_q}) : r_sh[WIDTH-1:0];
                dvd_d = dvd_q << 1;
                quo_d = {quo_q[QW-2:0], q_bit};
                cnt_d = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(DIV_STEPS - 1)) ? SCALE : DIVIDE;
            end
            SCALE: begin
                sx_d = fmul(ndc_x + ONE, HALF_W);
                sy_d = fmul(ONE - ndc_y, HALF_H);
                dp_d = ndc_z;
                valid_d = 1'b1;
                state_d = DONE;
            end
            DONE: if (i_ready) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = state_d == IDLE;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
            w_q <= '0;
            rem_q <= '0;
            dvd_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            sx_q <= '0;
            sy_q <= '0;
            dp_q <= '0;
            culled_q <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
            w_q <= w_d;
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
            sx_q <= sx_d;
            sy_q <= sy_d;
            dp_q <= dp_d;
            culled_q <= culled_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign o_ready = ready_q;
    assign o_screen_x = sx_q;
    assign o_screen_y = sy_q;
    assign o_depth = dp_q;
    assign o_culled = culled_q;
    assign o_valid = valid_q;
endmodule

// File: tb/tb_clip_to_screen.sv
// tb_clip_to_screen: directed scoreboard bench for clip_to_screen
module tb_clip_to_screen;
    logic         i_clk = 1'b0;
    logic         i_reset_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b1;
    logic [127:0] i_vertex = '0;
    logic         o_ready, o_culled, o_valid;
    logic [31:0]  o_screen_x, o_screen_y, o_depth;

    typedef struct {
        logic [31:0] sx;
        logic [31:0] sy;
        logic [31:0] dp;
        logic        cu;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;

    always #5 i_clk = ~i_clk;

    clip_to_screen #(.WIDTH(32), .FRAC(16), .VIEWPORT_W(640), .VIEWPORT_H(480)) dut (
        .i_clk(i_clk),
        .i_reset_n(i_reset_n),
        .i_vertex(i_vertex),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_screen_x(o_screen_x),
        .o_screen_y(o_screen_y),
        .o_depth(o_depth),
        .o_culled(o_culled),
        .o_valid(o_valid),
        .i_ready(i_ready)
    );

    function automatic exp_t mk(input logic [31:0] sx, input logic [31:0] sy,
                                input logic [31:0] dp, input logic cu);
        exp_t e;
        e.sx = sx;
        e.sy = sy;
        e.dp = dp;
        e.cu = cu;
        return e;
    endfunction

    function automatic logic [31:0] fm(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return 32'(p >>> 16);
    endfunction

    // Arithmetic reference: exact integer reciprocal, clamped, then the viewport map.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] z, input logic [31:0] w);
        longint r;
        logic [31:0] rc, nx, ny;
        if ($signed(w) <= 0) return mk(0, 0, 0, 1'b1);
        r = (longint'(1) << 32) / longint'(w);
        if (r > 64'sh7FFFFFFF) r = 64'sh7FFFFFFF;
        rc = 32'(r);
        nx = fm(x, rc);
        ny = fm(y, rc);
        return mk(fm(nx + 32'h00010000, 32'h01400000), fm(32'h00010000 - ny, 32'h00F00000),
                  fm(z, rc), 1'b0);
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                        input logic [31:0] w, input exp_t e);
        int n = 0;
        while (!o_ready && n < 100) begin
            tick();
            n++;
        end
        chk("send_ready", 32'(o_ready), 32'd1);
        i_vertex = {x, y, z, w};
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        sb.push_back(e);
    endtask

    // lat_exp counts edges after the accepting edge until o_valid is seen.
    task automatic recv(input string tag, input int lat_exp);
        int lat = 0;
        while (!o_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s_sb: observed=empty scoreboard expected=entry", tag);
            cur = mk(0, 0, 0, 1'b0);
        end else begin
            cur = sb.pop_front();
        end
        chk({tag, "_x"}, o_screen_x, cur.sx);
        chk({tag, "_y"}, o_screen_y, cur.sy);
        chk({tag, "_z"}, o_depth, cur.dp);
        chk({tag, "_cul"}, 32'(o_culled), 32'(cur.cu));
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_x", o_screen_x, 32'd0);
        chk("rst_cul", 32'(o_culled), 32'd0);
        @(negedge i_clk) i_reset_n = 1'b1;
        tick();
        chk("rel_ready", 32'(o_ready), 32'd1);

        send(32'h0, 32'h0, 32'h00008000, 32'h00010000, mk(32'h01400000, 32'h00F00000, 32'h00008000, 1'b0));
        recv("c1", 34);
        tick();

        send(32'h00020000, 32'hFFFE0000, 32'h00010000, 32'h00020000,
             mk(32'h02800000, 32'h01E00000, 32'h00008000, 1'b0));
        recv("c2", 34);
        tick();
        chk("c2_ready_after", 32'(o_ready), 32'd1);
        chk("c2_valid_after", 32'(o_valid), 32'd0);

        send(32'h00010000, 32'h00010000, 32'h00010000, 32'h0, mk(0, 0, 0, 1'b1));
        chk("c3a_ready", 32'(o_ready), 32'd0);
        recv("c3a", 0);
        tick();
        send(32'h00030000, 32'h00050000, 32'h00010000, 32'hFFFF0000, mk(0, 0, 0, 1'b1));
        recv("c3b", 0);
        tick();

        send(32'h00018000, 32'hFFFF4000, 32'h00010000, 32'h00030000,
             model(32'h00018000, 32'hFFFF4000, 32'h00010000, 32'h00030000));
        chk("m1_cul_clear", 32'(o_culled), 32'd0);
        chk("m1_busy", 32'(o_ready), 32'd0);
        recv("m1", 34);
        tick();

        i_ready = 1'b0;
        send(32'h0, 32'h0, 32'h00008000, 32'h00010000, mk(32'h01400000, 32'h00F00000, 32'h00008000, 1'b0));
        recv("c4", 34);
        i_vertex = {32'h00020000, 32'hFFFE0000, 32'h00010000, 32'h00020000};
        i_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("c4_hold_valid", 32'(o_valid), 32'd1);
            chk("c4_hold_x", o_screen_x, cur.sx);
            chk("c4_hold_y", o_screen_y, cur.sy);
            chk("c4_hold_ready", 32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        tick();
        chk("c4_ready_up", 32'(o_ready), 32'd1);
        chk("c4_valid_down", 32'(o_valid), 32'd0);
        tick();
        i_valid = 1'b0;
        sb.push_back(mk(32'h02800000, 32'h01E00000, 32'h00008000, 1'b0));
        chk("c4_second_acc", 32'(o_ready), 32'd0);
        recv("c4b", 34);
        tick();

        send(32'h00020000, 32'hFFFE0000, 32'h00010000, 32'h00020000,
             mk(32'h02800000, 32'h01E00000, 32'h00008000, 1'b0));
        repeat (10) tick();
        chk("c5_busy", 32'(o_ready), 32'd0);
        #3;
        i_reset_n = 1'b0;
        #1;
        chk("c5_rst_x", o_screen_x, 32'd0);
        chk("c5_rst_y", o_screen_y, 32'd0);
        chk("c5_rst_z", o_depth, 32'd0);
        chk("c5_rst_valid", 32'(o_valid), 32'd0);
        chk("c5_rst_ready", 32'(o_ready), 32'd0);
        sb.delete();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk) i_reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (o_valid) seen++;
        end
        chk("c5_no_valid", 32'(seen), 32'd0);
        send(32'h00020000, 32'hFFFE0000, 32'h00010000, 32'h00020000,
             mk(32'h02800000, 32'h01E00000, 32'h00008000, 1'b0));
        recv("c5", 34);
        tick();

        send(32'h0, 32'h0, 32'h0, 32'h00000001, mk(32'h01400000, 32'h00F00000, 32'h0, 1'b0));
        recv("c6", 34);
        tick();

        send(32'hFFFF0000, 32'h00008000, 32'hFFFF8000, 32'h00040000,
             model(32'hFFFF0000, 32'h00008000, 32'hFFFF8000, 32'h00040000));
        recv("m2", 34);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
